// File: rtl/issue_group_buffer.sv
// issue_group_buffer: in-order superscalar issue buffer holding one decoded bundle.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid_i / in_ready_o            bundle handshake from decode (whole bundles only)
//   in_count_i, in_instr_i             bundle size and slot-packed payloads (slot 0 oldest)
//   in_branch_i, in_mem_*_i            per-slot decode flags
//   slot_branch_o, slot_mem_*_o        held flags for the mask logic, zero on empty slots
//   branch_mask_i, mem_mask_i          masks returned combinationally by the mask logic
//   issue_valid_o, issue_instr_o       issued prefix and slot-aligned held payloads
//   issue_count_o                      size of the issued prefix
//   issue_ready_i                      execute accepts the whole offered group
//   flush_i                            squash all held instructions
module issue_group_buffer #(
    parameter int NUM_WIDTH = 3,
    parameter int INSTR_W   = 32,
    parameter int CNT_W     = $clog2(NUM_WIDTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [CNT_W-1:0]             in_count_i,
    input  logic [NUM_WIDTH*INSTR_W-1:0] in_instr_i,
    input  logic [NUM_WIDTH-1:0]         in_branch_i,
    input  logic [NUM_WIDTH-1:0]         in_mem_read_i,
    input  logic [NUM_WIDTH-1:0]         in_mem_write_i,
    output logic [NUM_WIDTH-1:0]         slot_branch_o,
    output logic [NUM_WIDTH-1:0]         slot_mem_read_o,
    output logic [NUM_WIDTH-1:0]         slot_mem_write_o,
    input  logic [NUM_WIDTH-1:0]         branch_mask_i,
    input  logic [NUM_WIDTH-1:0]         mem_mask_i,
    output logic [NUM_WIDTH-1:0]         issue_valid_o,
    output logic [NUM_WIDTH*INSTR_W-1:0] issue_instr_o,
    output logic [CNT_W-1:0]             issue_count_o,
    input  logic                         issue_ready_i,
    input  logic                         flush_i
);
    logic [CNT_W-1:0]                  occ_q, occ_d;
    logic [NUM_WIDTH-1:0][INSTR_W-1:0] instr_q, instr_d;
    logic [NUM_WIDTH-1:0]              br_q, br_d, mr_q, mr_d, mw_q, mw_d;
    logic [NUM_WIDTH-1:0]              valid, pfx;
    logic [CNT_W-1:0]                  k, issued, rem, cnt;
    logic                              run, fire, load;
    always_comb begin
        valid = '0;
        pfx   = '0;
        k     = '0;
        run   = 1'b1;
        // k is the length of the leading run of valid slots that both masks pass
        for (int i = 0; i < NUM_WIDTH; i++) begin
            valid[i] = CNT_W'(i) < occ_q;
            run      = run & valid[i] & branch_mask_i[i] & mem_mask_i[i];
            pfx[i]   = run;
            k        = k + CNT_W'(run);
        end
        fire          = issue_ready_i & ~flush_i & (k != '0);
        issued        = fire ? k : '0;
        rem           = occ_q - issued;
        in_ready_o    = rst_n & ~flush_i & (rem == '0);
        load          = in_valid_i & in_ready_o;
        cnt           = (in_count_i > CNT_W'(NUM_WIDTH)) ? CNT_W'(NUM_WIDTH) : in_count_i;
        issue_valid_o = flush_i ? '0 : pfx;
        issue_count_o = flush_i ? '0 : k;
    end
    always_comb begin
        instr_d = instr_q;
        br_d    = br_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        occ_d   = rem;
        // compaction: leftover slot j+issued moves to slot j; vacated slots keep stale data
        for (int j = 0; j < NUM_WIDTH; j++) begin
            for (int s = 0; s < NUM_WIDTH; s++) begin
                if (s == j + int'(issued)) begin
                    instr_d[j] = instr_q[s];
                    br_d[j]    = br_q[s];
                    mr_d[j]    = mr_q[s];
                    mw_d[j]    = mw_q[s];
                end
            end
        end
        if (flush_i) begin
            occ_d = '0;
        end else if (load) begin
            occ_d   = cnt;
            instr_d = in_instr_i;
            br_d    = in_branch_i;
            mr_d    = in_mem_read_i;
            mw_d    = in_mem_write_i;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= '0;
            instr_q <= '0;
            br_q    <= '0;
            mr_q    <= '0;
            mw_q    <= '0;
        end else begin
            occ_q   <= occ_d;
            instr_q <= instr_d;
            br_q    <= br_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
        end
    end
    assign slot_branch_o    = br_q & valid;
    assign slot_mem_read_o  = mr_q & valid;
    assign slot_mem_write_o = mw_q & valid;
    assign issue_instr_o    = instr_q;
endmodule

// File: tb/tb_issue_group_buffer.sv
// tb_issue_group_buffer: directed table, reset sequence and random run against a queue model.
module tb_issue_group_buffer;
    localparam int NW = 3;
    localparam int IW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [CW-1:0] in_count = '0;
    logic [NW*IW-1:0] in_instr = '0;
    logic [NW-1:0] in_branch = '0, in_mem_read = '0, in_mem_write = '0;
    logic [NW-1:0] slot_branch, slot_mem_read, slot_mem_write;
    logic [NW-1:0] branch_mask, mem_mask, issue_valid;
    logic [NW*IW-1:0] issue_instr;
    logic [CW-1:0] issue_count;
    logic          issue_ready = 1'b0, flush = 1'b0;

    issue_group_buffer #(.NUM_WIDTH(NW), .INSTR_W(IW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_count_i(in_count), .in_instr_i(in_instr),
        .in_branch_i(in_branch), .in_mem_read_i(in_mem_read), .in_mem_write_i(in_mem_write),
        .slot_branch_o(slot_branch), .slot_mem_read_o(slot_mem_read), .slot_mem_write_o(slot_mem_write),
        .branch_mask_i(branch_mask), .mem_mask_i(mem_mask),
        .issue_valid_o(issue_valid), .issue_instr_o(issue_instr), .issue_count_o(issue_count),
        .issue_ready_i(issue_ready), .flush_i(flush)
    );

    always #5 clk = ~clk;

    // Mask logic: a branch may only issue from slot 0 and ends the group;
    // at most one memory op per group. Slot 0 always passes.
    logic pb, pm;
    always_comb begin
        pb = 1'b0;
        pm = 1'b0;
        branch_mask = '0;
        mem_mask = '0;
        for (int i = 0; i < NW; i++) begin
            branch_mask[i] = (i == 0) || (!slot_branch[i] && !pb);
            mem_mask[i] = (i == 0) || !((slot_mem_read[i] | slot_mem_write[i]) && pm);
            pb = pb | slot_branch[i];
            pm = pm | slot_mem_read[i] | slot_mem_write[i];
        end
    end

    typedef struct {
        logic [IW-1:0] ins;
        logic br, mr, mw;
    } item_t;
    item_t q[$];

    int compared = 0, mismatched = 0;
    logic [NW-1:0] act_iv;
    logic [CW-1:0] act_cnt;
    logic act_rdy;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Group size from the held instructions, using the mask rules directly.
    function automatic int model_k();
        int n = 0;
        bit sb = 0, sm = 0;
        for (int i = 0; i < q.size(); i++) begin
            bit m = q[i].mr | q[i].mw;
            if (i > 0 && (q[i].br || sb || (m && sm))) break;
            sb |= q[i].br;
            sm |= m;
            n++;
        end
        return n;
    endfunction

    // One cycle: inputs already driven; check mid-cycle, then advance the model on the edge.
    task automatic cyc();
        int k, occ, rem;
        bit fire, rdy;
        logic [NW-1:0] eiv, esb, emr, emw;
        logic [NW*IW-1:0] ein, msk;
        assert (in_count <= NW);
        @(negedge clk);
        occ = q.size();
        k = flush ? 0 : model_k();
        fire = issue_ready && !flush && k > 0;
        rem = occ - (fire ? k : 0);
        rdy = !flush && rem == 0;
        eiv = '0; esb = '0; emr = '0; emw = '0; ein = '0; msk = '0;
        for (int i = 0; i < NW; i++) begin
            eiv[i] = i < k;
            if (i < occ) begin
                esb[i] = q[i].br;
                emr[i] = q[i].mr;
                emw[i] = q[i].mw;
                ein[i*IW +: IW] = q[i].ins;
                msk[i*IW +: IW] = '1;
            end
        end
        act_iv = issue_valid;
        act_cnt = issue_count;
        act_rdy = in_ready;
        chk("issue_valid", 128'(issue_valid), 128'(eiv));
        chk("issue_count", 128'(issue_count), 128'(k));
        chk("in_ready", 128'(in_ready), 128'(rdy));
        chk("slot_flags", 128'({slot_branch, slot_mem_read, slot_mem_write}), 128'({esb, emr, emw}));
        chk("issue_instr", 128'(issue_instr & msk), 128'(ein));
        @(posedge clk);
        if (flush) q.delete();
        else if (in_valid && rdy) begin
            q.delete();
            for (int i = 0; i < int'(in_count); i++)
                q.push_back('{in_instr[i*IW +: IW], in_branch[i], in_mem_read[i], in_mem_write[i]});
        end else if (fire) repeat (k) void'(q.pop_front());
        #1;
    endtask

    typedef struct {
        logic v;
        logic [CW-1:0] cnt;
        logic [NW-1:0] br, mr, mw;
        logic rdy, fl;
        logic [NW-1:0] e_iv;
        logic [CW-1:0] e_cnt;
        logic e_rdy;
    } vec_t;
    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1, 3, 3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 1};
        tbl[1]  = '{1, 3, 3'b001, 3'b000, 3'b000, 1, 0, 3'b111, 3, 1};
        tbl[2]  = '{1, 3, 3'b100, 3'b010, 3'b000, 1, 0, 3'b001, 1, 0};
        tbl[3]  = '{1, 3, 3'b100, 3'b010, 3'b000, 1, 0, 3'b011, 2, 1};
        tbl[4]  = '{0, 0, 3'b000, 3'b000, 3'b000, 1, 0, 3'b011, 2, 0};
        tbl[5]  = '{1, 3, 3'b000, 3'b000, 3'b000, 1, 0, 3'b001, 1, 1};
        tbl[6]  = '{1, 2, 3'b000, 3'b000, 3'b001, 0, 0, 3'b111, 3, 0};
        tbl[7]  = '{1, 2, 3'b000, 3'b000, 3'b001, 0, 0, 3'b111, 3, 0};
        tbl[8]  = '{1, 2, 3'b000, 3'b000, 3'b001, 0, 0, 3'b111, 3, 0};
        tbl[9]  = '{1, 2, 3'b000, 3'b000, 3'b001, 0, 0, 3'b111, 3, 0};
        tbl[10] = '{1, 2, 3'b000, 3'b000, 3'b001, 1, 0, 3'b111, 3, 1};
        tbl[11] = '{1, 3, 3'b000, 3'b000, 3'b000, 1, 1, 3'b000, 0, 0};
        tbl[12] = '{0, 0, 3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 1};
        tbl[13] = '{1, 0, 3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 1};
        tbl[14] = '{0, 0, 3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 0, 1};

        #12;
        chk("reset_in_ready", 128'(in_ready), 128'(0));
        chk("reset_outputs", 128'({issue_valid, issue_count, slot_branch, slot_mem_read, slot_mem_write}), 128'(0));
        chk("reset_instr", 128'(issue_instr), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 15; r++) begin
            in_valid = tbl[r].v; in_count = tbl[r].cnt;
            in_branch = tbl[r].br; in_mem_read = tbl[r].mr; in_mem_write = tbl[r].mw;
            issue_ready = tbl[r].rdy; flush = tbl[r].fl;
            for (int s = 0; s < NW; s++) in_instr[s*IW +: IW] = 32'hA000_0000 + r * 16 + s;
            cyc();
            chk($sformatf("tbl%0d_iv", r), 128'(act_iv), 128'(tbl[r].e_iv));
            chk($sformatf("tbl%0d_cnt", r), 128'(act_cnt), 128'(tbl[r].e_cnt));
            chk($sformatf("tbl%0d_rdy", r), 128'(act_rdy), 128'(tbl[r].e_rdy));
        end

        in_valid = 1; in_count = 3; in_branch = 0; in_mem_read = 0; in_mem_write = 0;
        in_instr = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}; issue_ready = 0; flush = 0;
        cyc();
        in_valid = 0;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("async_rst_outputs", 128'({issue_valid, issue_count, slot_branch, slot_mem_read, slot_mem_write, in_ready}), 128'(0));
        chk("async_rst_instr", 128'(issue_instr), 128'(0));
        #2 rst_n = 1'b1;
        in_valid = 1; in_count = 0; issue_ready = 1;
        cyc();
        chk("zero_cnt_accept_rdy", 128'(act_rdy), 128'(1));
        in_valid = 0;
        cyc();
        chk("zero_cnt_no_issue", 128'({act_iv, act_cnt, act_rdy}), 128'({3'b000, 2'd0, 1'b1}));

        for (int c = 0; c < 3000; c++) begin
            in_valid = $urandom_range(0, 9) < 7;
            in_count = CW'($urandom_range(0, NW));
            in_branch = NW'($urandom) & NW'($urandom);
            in_mem_read = NW'($urandom) & NW'($urandom);
            in_mem_write = NW'($urandom) & NW'($urandom) & NW'($urandom);
            for (int s = 0; s < NW; s++) in_instr[s*IW +: IW] = $urandom;
            issue_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 9) == 0;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
